ep4_cmd_receiver: RTL and testbench

//  Parametrised EP4 command receiver. Runs in the FX2 EP4 clock domain.

---
 rtl/ep4_cmd_receiver_if.sv | 34 +++
 rtl/ep4_cmd_receiver.sv | 115 +++++++++++
 tb/tb_ep4_cmd_receiver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ep4_cmd_receiver_if.sv
// EP4 command receiver bus: FX2 EP4 byte source and controller command handshake.
// master = EP4 source / controller side, slave = receiver.
interface ep4_cmd_receiver_if #(
    parameter int MAX_CMD_BYTES = 8,
    parameter int LEN_WIDTH     = 16
);
    logic                       rx_enable;
    logic [7:0]                 ep4_cmd_id;
    logic [LEN_WIDTH-1:0]       ep4_cmd_length;
    logic                       ep4_ready;
    logic                       ep4_read;
    logic [7:0]                 ep4_data;
    logic                       cmd_valid;
    logic                       cmd_ack;
    logic [7:0]                 cmd_id;
    logic [LEN_WIDTH-1:0]       cmd_length;
    logic [MAX_CMD_BYTES*8-1:0] cmd_data;
    logic                       cmd_overflow;
    logic                       cmd_csum_err;

    modport master (
        output rx_enable, ep4_cmd_id, ep4_cmd_length,
        output ep4_ready, ep4_data, cmd_ack,
        input  ep4_read, cmd_valid, cmd_id, cmd_length,
        input  cmd_data, cmd_overflow, cmd_csum_err
    );

    modport slave (
        input  rx_enable, ep4_cmd_id, ep4_cmd_length,
        input  ep4_ready, ep4_data, cmd_ack,
        output ep4_read, cmd_valid, cmd_id, cmd_length,
        output cmd_data, cmd_overflow, cmd_csum_err
    );
endinterface

// File: rtl/ep4_cmd_receiver.sv
// EP4 command receiver: fetches one framed command and holds it for the controller.
// Optional payload checksum enabled by defining EP4_CMD_CHECKSUM_EN.
module ep4_cmd_receiver #(
    parameter int MAX_CMD_BYTES = 8,
    parameter int LEN_WIDTH     = 16,
    parameter int CNT_WIDTH     = 16
) (
    input logic            ep4_clk,
    input logic            reset,
    ep4_cmd_receiver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                     state, state_nxt;
    logic                       read_q;
    logic [7:0]                 id_q;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [MAX_CMD_BYTES*8-1:0] data_q;
    logic                       ovf_q;
    logic [CNT_WIDTH-1:0]       count;
    logic [CNT_WIDTH-1:0]       len_ext;
    logic                       hdr;
    logic                       xfer;
    logic                       last;

    // Zero-extended so a maximum-length frame never wraps the compare.
    assign len_ext = CNT_WIDTH'(len_q);
    assign hdr  = (state == IDLE) && bus.rx_enable && bus.ep4_ready;
    assign xfer = (state == ACTIVE) && read_q && bus.ep4_ready;
    assign last = xfer && (count == len_ext - CNT_WIDTH'(1));

    // State register.
    always_ff @(posedge ep4_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; ack only matters while holding a command.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hdr)
                    state_nxt = (bus.ep4_cmd_length == '0) ? DONE : ACTIVE;
            end
            ACTIVE: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (bus.cmd_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header latch, byte capture, overflow flag and read strobe.
    always_ff @(posedge ep4_clk or posedge reset) begin
        if (reset) begin
            read_q <= 1'b0;
            id_q   <= '0;
            len_q  <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            count  <= '0;
        end else if (hdr) begin
            id_q   <= bus.ep4_cmd_id;
            len_q  <= bus.ep4_cmd_length;
            data_q <= '0;
            ovf_q  <= 1'b0;
            count  <= '0;
            read_q <= (bus.ep4_cmd_length != '0);
        end else if (xfer) begin
            for (int k = 0; k < MAX_CMD_BYTES; k++) begin
                if (count == CNT_WIDTH'(k))
                    data_q[8*k +: 8] <= bus.ep4_data;
            end
            if (count >= CNT_WIDTH'(MAX_CMD_BYTES))
                ovf_q <= 1'b1;
            count <= count + CNT_WIDTH'(1);
            if (last)
                read_q <= 1'b0;
        end
    end

`ifdef EP4_CMD_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_err;

    // Running XOR over every transferred byte, overflow bytes included.
    always_ff @(posedge ep4_clk or posedge reset) begin
        if (reset) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (hdr) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (xfer) begin
            csum <= csum ^ bus.ep4_data;
            if (last)
                csum_err <= ((csum ^ bus.ep4_data) != 8'h00);
        end
    end

    assign bus.cmd_csum_err = csum_err;
`else
    assign bus.cmd_csum_err = 1'b0;
`endif

    assign bus.ep4_read     = read_q;
    assign bus.cmd_valid    = (state == DONE);
    assign bus.cmd_id       = id_q;
    assign bus.cmd_length   = len_q;
    assign bus.cmd_data     = data_q;
    assign bus.cmd_overflow = ovf_q;
endmodule

// File: tb/tb_ep4_cmd_receiver.sv
// Directed bench for ep4_cmd_receiver.
// Define EP4_CMD_CHECKSUM_EN to also exercise the checksum frames.
module tb_ep4_cmd_receiver;
    logic ep4_clk = 1'b0;
    logic reset   = 1'b1;

    ep4_cmd_receiver_if #(.MAX_CMD_BYTES(8), .LEN_WIDTH(16)) bus ();

    ep4_cmd_receiver #(
        .MAX_CMD_BYTES(8),
        .LEN_WIDTH(16),
        .CNT_WIDTH(16)
    ) dut (
        .ep4_clk(ep4_clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 ep4_clk = ~ep4_clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] pay [0:15];
    int edges;
    int xfers;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Present a header and run until cmd_valid or a cycle budget expires.
    task automatic send_frame(input logic [7:0] id, input int len,
                              input bit toggle);
        logic pre;
        bus.rx_enable      = 1'b1;
        bus.ep4_cmd_id     = id;
        bus.ep4_cmd_length = 16'(len);
        bus.ep4_ready      = 1'b1;
        bus.ep4_data       = pay[0];
        edges = 0;
        xfers = 0;
        do begin
            pre = bus.ep4_read && bus.ep4_ready;
            @(posedge ep4_clk);
            #1;
            edges++;
            if (pre) xfers++;
            bus.rx_enable = 1'b0;
            bus.ep4_data  = pay[xfers & 15];
            if (toggle) bus.ep4_ready = (edges % 2 == 0);
        end while (!bus.cmd_valid && edges < 200);
        bus.ep4_ready = 1'b0;
        chk("valid", 64'(bus.cmd_valid), 64'd1);
        chk("read_off", 64'(bus.ep4_read), 64'd0);
    endtask

    task automatic do_ack();
        bus.cmd_ack = 1'b1;
        @(posedge ep4_clk);
        #1;
        bus.cmd_ack = 1'b0;
        chk("ack_clr", 64'(bus.cmd_valid), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.cmd_valid), 64'd0);
        chk({tag, "_read"}, 64'(bus.ep4_read), 64'd0);
        chk({tag, "_id"}, 64'(bus.cmd_id), 64'd0);
        chk({tag, "_len"}, 64'(bus.cmd_length), 64'd0);
        chk({tag, "_data"}, bus.cmd_data, 64'd0);
        chk({tag, "_ovf"}, 64'(bus.cmd_overflow), 64'd0);
        chk({tag, "_csum"}, 64'(bus.cmd_csum_err), 64'd0);
    endtask

    initial begin
        bus.rx_enable      = 1'b0;
        bus.ep4_cmd_id     = '0;
        bus.ep4_cmd_length = '0;
        bus.ep4_ready      = 1'b0;
        bus.ep4_data       = '0;
        bus.cmd_ack        = 1'b0;
        for (int i = 0; i < 16; i++) pay[i] = '0;
        repeat (2) @(posedge ep4_clk);
        #1;
        chk_zero("rst");
        reset = 1'b0;
        @(posedge ep4_clk);
        #1;

        // len=3 with ready held high
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'h05, 3, 1'b0);
        chk("t1_edges", 64'(edges), 64'd4);
        chk("t1_xfers", 64'(xfers), 64'd3);
        chk("t1_data", bus.cmd_data, 64'h332211);
        chk("t1_id", 64'(bus.cmd_id), 64'h05);
        chk("t1_len", 64'(bus.cmd_length), 64'd3);
        chk("t1_ovf", 64'(bus.cmd_overflow), 64'd0);
        @(posedge ep4_clk);
        #1;
        chk("t1_hold", 64'(bus.cmd_valid), 64'd1);
        chk("t1_hold_data", bus.cmd_data, 64'h332211);
        do_ack();

        // zero-length frame, back-to-back after the ack
        send_frame(8'd31, 0, 1'b0);
        chk("t2_edges", 64'(edges), 64'd1);
        chk("t2_xfers", 64'(xfers), 64'd0);
        chk("t2_id", 64'(bus.cmd_id), 64'd31);
        chk("t2_data", bus.cmd_data, 64'd0);
        chk("t2_csum", 64'(bus.cmd_csum_err), 64'd0);
        do_ack();

        // over-length frame
        for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
        send_frame(8'h44, 10, 1'b0);
        chk("t3_edges", 64'(edges), 64'd11);
        chk("t3_xfers", 64'(xfers), 64'd10);
        chk("t3_data", bus.cmd_data, 64'h0807060504030201);
        chk("t3_ovf", 64'(bus.cmd_overflow), 64'd1);
        chk("t3_len", 64'(bus.cmd_length), 64'd10);
        do_ack();

        // ready toggling stalls the transfer
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
        send_frame(8'h07, 4, 1'b1);
        chk("t4_edges", 64'(edges), 64'd9);
        chk("t4_xfers", 64'(xfers), 64'd4);
        chk("t4_data", bus.cmd_data, 64'hD4C3B2A1);
        chk("t4_ovf", 64'(bus.cmd_overflow), 64'd0);
        do_ack();

        // reset after 2 of 5 bytes
        bus.rx_enable      = 1'b1;
        bus.ep4_cmd_id     = 8'h66;
        bus.ep4_cmd_length = 16'd5;
        bus.ep4_ready      = 1'b1;
        bus.ep4_data       = 8'hE1;
        repeat (3) @(posedge ep4_clk);
        #1;
        chk("t5_mid_read", 64'(bus.ep4_read), 64'd1);
        chk("t5_mid_id", 64'(bus.cmd_id), 64'h66);
        bus.rx_enable = 1'b0;
        bus.ep4_ready = 1'b0;
        reset = 1'b1;
        #2;
        chk_zero("t5_rst");
        reset = 1'b0;
        @(posedge ep4_clk);
        #1;
        chk("t5_idle", 64'(bus.cmd_valid), 64'd0);
        pay[0] = 8'h5A; pay[1] = 8'hA5;
        send_frame(8'h02, 2, 1'b0);
        chk("t5_edges", 64'(edges), 64'd3);
        chk("t5_data", bus.cmd_data, 64'hA55A);
        chk("t5_len", 64'(bus.cmd_length), 64'd2);
        chk("t5_id", 64'(bus.cmd_id), 64'h02);
        chk("t5_ovf", 64'(bus.cmd_overflow), 64'd0);
        do_ack();

`ifdef EP4_CMD_CHECKSUM_EN
        pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h26;
        send_frame(8'h09, 3, 1'b0);
        chk("t6_good", 64'(bus.cmd_csum_err), 64'd0);
        chk("t6_good_data", bus.cmd_data, 64'h263412);
        do_ack();
        pay[2] = 8'h27;
        send_frame(8'h0A, 3, 1'b0);
        chk("t6_bad", 64'(bus.cmd_csum_err), 64'd1);
        chk("t6_bad_data", bus.cmd_data, 64'h273412);
        do_ack();
        pay[0] = 8'h3C; pay[1] = 8'h3C;
        send_frame(8'h0B, 2, 1'b0);
        chk("t6_next", 64'(bus.cmd_csum_err), 64'd0);
        chk("t6_next_id", 64'(bus.cmd_id), 64'h0B);
        do_ack();
`else
        pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h27;
        send_frame(8'h0A, 3, 1'b0);
        chk("t6_off", 64'(bus.cmd_csum_err), 64'd0);
        do_ack();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
